sdram_controller: RTL and testbench
===================================

Name: sdram_controller

Overview:
Single-port SDRAM responder serving the ROM controller's 32-bit request interface (req/ack/valid). It turns each 32-bit word read or write into an ACTIVE followed by a burst-of-2 READ or WRITE with auto-precharge on a 16-bit SDR SDRAM. It also owns power-up initialisation and periodic auto-refresh. It sits between the ROM controller and the SDRAM chip pins.

Parameters:
INIT_CYCLES, 20000, NOP cycles after reset before PRECHARGE ALL (≥100 µs at clk).
REFRESH_CYCLES, 750, clk cycles between AUTO REFRESH commands.
T_RCD, 2, ACTIVE→READ/WRITE delay in cycles.
T_RP, 2, precharge period in cycles.
T_RC, 7, AUTO REFRESH→next command in cycles.
CAS_LATENCY, 2, CAS latency (2 or 3), programmed into mode register.

Ports:
clk  in  1  system clock; also drives the SDRAM clock.
reset  in  1  asynchronous, active-high.
addr  in  23  32-bit word address.
data  in  32  write data.
we  in  1  1=write, 0=read.
req  in  1  request, level-sensitive.
ack  out  1  one-cycle pulse when the request is accepted.
valid  out  1  one-cycle pulse when q holds read data.
q  out  32  read data.
ready  out  1  high once initialisation completes.
sdram_a  out  13  address bus.
sdram_ba  out  2  bank.
sdram_dq  inout  16  data bus.
sdram_dqm  out  2  byte masks.
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
sdram_cke  out  1  clock enable.

Behaviour:
- Reset clock/polarity: reset reset, asynchronous, active-high; clock clk.
- While reset is asserted:
  - ack=0, valid=0, q=0, ready=0, cke=0.
  - cs_n/ras_n/cas_n/we_n=1 (INHIBIT), dqm=11, dq tri-stated.
  - FSM=INIT, refresh counter cleared.
- Reset mid-operation aborts any access; no ack or valid follows, and init restarts.
- Address map:
  - row=addr[22:10], ba=addr[9:8], column={addr[7:0],1'b0}.
  - Burst 2, sequential.
  - First (even) halfword ↔ q/data[31:16]; second halfword ↔ [15:0].
- INIT sequence:
  - cke=1 from the first cycle after reset deasserts.
  - NOP for INIT_CYCLES.
  - PRECHARGE ALL (A10=1), then wait T_RP.
  - AUTO REFRESH ×2, each followed by T_RC.
  - LOAD MODE with A=000_0_00_CL_0_001, then wait 2 cycles.
  - Enter IDLE; ready=1 and dqm=00 from then on.
- During INIT, req is ignored and ack stays 0.
- Refresh:
  - The counter runs from the end of INIT and sets refresh_pending on reaching REFRESH_CYCLES, then restarts.
  - In IDLE, pending refresh beats req: AUTO REFRESH, wait T_RC, back to IDLE, pending cleared.
  - Refresh never produces an ack.
- IDLE with req=1 and no pending refresh (cycle 0):
  - Issue ACTIVE and pulse ack=1.
  - Latch addr, data and we.
  - The requester may change inputs from cycle 1.
- Read (cycles relative to ACTIVE at cycle 0):
  - NOP until cycle T_RCD, then READ with A10=1.
  - dq sampled into input registers at cycles T_RCD+CL+1 and T_RCD+CL+2.
  - q updated and valid=1 in cycle T_RCD+CL+2 (6 with defaults).
  - FSM is in IDLE in that same cycle and may accept the next request there.
- Write:
  - WRITE with A10=1 at cycle T_RCD, driving data[31:16].
  - data[15:0] driven at T_RCD+1; dq released at T_RCD+2.
  - IDLE in cycle T_RCD+5 (7 with defaults); no valid pulse.
- q holds its value until the next read completes.
- A single req held high for back-to-back accesses yields one ack per access.
- req asserted in a cycle where refresh wins is served after refresh completes, with no loss.
- All commands not listed above are NOP (cs_n=0, ras_n/cas_n/we_n=1).

Test Plan:
- Reset, release → sdram_cke=1 next cycle. PRECHARGE ALL at cycle INIT_CYCLES. 2×AUTO REFRESH spaced T_RC. LOAD MODE A=0x021. ready=1 after.
- Write addr=0x000405, data=0xDEADBEEF:
  - ACTIVE row=1, ba=0; ack in cycle 0.
  - WRITE col=0x00A at cycle 2; dq=0xDEAD, then 0xBEEF.
  - Then read the same address → valid in cycle 6, q=0xDEADBEEF.
- req held high for two reads → ack at cycles 0 and 6, valid at 6 and 12; no command overlap violates T_RCD/T_RP.
- Force the refresh counter to expire at the same cycle req rises in IDLE → AUTO REFRESH issued first with no ack. ACTIVE/ack at T_RC cycles later. Data returned correctly.
- Assert reset at read cycle 4 → no valid, q=0, INHIBIT/cke=0 immediately. Full init repeats after release.
- req during INIT → no ack and no ACTIVE until ready=1; then ack within 1 cycle.

Source files
------------

// File: rtl/sdram_controller_if.sv
// Requester-side bus of the SDRAM controller: 32-bit word request with
// ack/valid handshake and the init-complete flag.
interface sdram_controller_if;
  logic [22:0] addr;
  logic [31:0] data;
  logic        we;
  logic        req;
  logic        ack;
  logic        valid;
  logic [31:0] q;
  logic        ready;

  modport master (output addr, data, we, req, input ack, valid, q, ready);
  modport slave  (input addr, data, we, req, output ack, valid, q, ready);
endinterface

// File: rtl/sdram_controller.sv
// SDR SDRAM responder: power-up init, periodic auto-refresh and 32-bit word
// accesses as ACTIVE + burst-of-2 READ/WRITE with auto-precharge.
module sdram_controller #(
  parameter int unsigned INIT_CYCLES    = 20000,
  parameter int unsigned REFRESH_CYCLES = 750,
  parameter int unsigned T_RCD          = 2,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned T_RC           = 7,
  parameter int unsigned CAS_LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  sdram_controller_if.slave bus,
  output logic [12:0]       sdram_a,
  output logic [1:0]        sdram_ba,
  inout  wire  [15:0]       sdram_dq,
  output logic [1:0]        sdram_dqm,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic              sdram_cke
);

  localparam int unsigned CW = $clog2(INIT_CYCLES + T_RC + T_RP + T_RCD + CAS_LATENCY + 4);
  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000, CMD_REF = 4'b0001, CMD_PRE = 4'b0010, CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100, CMD_RD  = 4'b0101, CMD_NOP = 4'b0111, CMD_INH = 4'b1111
  } cmd_t;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_REF1, S_REF2, S_MRS, S_IDLE, S_ACT, S_WR
  } state_t;

  state_t                 state, nxt;
  cmd_t                   cmd;
  logic [CW-1:0]          cnt;
  logic [RW-1:0]          rcnt;
  logic                   ref_pend;
  logic [7:0]             lat_col;
  logic [1:0]             lat_ba;
  logic                   lat_we;
  logic [31:0]            lat_data;
  logic [15:0]            dq_out;
  logic                   dq_oe;
  logic [15:0]            rd_hi;
  logic [CAS_LATENCY+1:0] rd_sr;

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_dq = dq_oe ? dq_out : 'z;

  // Every timed gap goes through S_WAIT: cnt = gap-2 makes the command in
  // state nxt land exactly `gap` cycles after the one that entered S_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      nxt       <= S_INIT;
      cmd       <= CMD_INH;
      cnt       <= CW'(INIT_CYCLES - 1);
      rcnt      <= '0;
      ref_pend  <= 1'b0;
      lat_col   <= '0;
      lat_ba    <= '0;
      lat_we    <= 1'b0;
      lat_data  <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      rd_hi     <= '0;
      rd_sr     <= '0;
      sdram_a   <= '0;
      sdram_ba  <= '0;
      sdram_dqm <= '1;
      sdram_cke <= 1'b0;
      bus.ack   <= 1'b0;
      bus.valid <= 1'b0;
      bus.q     <= '0;
      bus.ready <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
      cmd       <= CMD_NOP;
      bus.ack   <= 1'b0;
      dq_oe     <= 1'b0;

      // Read return path runs off the READ issue time, independent of the FSM,
      // so the next ACTIVE can overlap the second data beat.
      rd_sr     <= {rd_sr[CAS_LATENCY:0], 1'b0};
      if (rd_sr[CAS_LATENCY]) rd_hi <= sdram_dq;
      bus.valid <= rd_sr[CAS_LATENCY+1];
      if (rd_sr[CAS_LATENCY+1]) bus.q <= {rd_hi, sdram_dq};

      if (bus.ready) begin
        if (rcnt == RW'(REFRESH_CYCLES - 1)) begin
          rcnt     <= '0;
          ref_pend <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end

      case (state)
        S_INIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cmd     <= CMD_PRE;
            sdram_a <= 13'h0400;
            cnt     <= CW'(T_RP - 2);
            nxt     <= S_REF1;
            state   <= S_WAIT;
          end
        end
        S_REF1, S_REF2: begin
          cmd   <= CMD_REF;
          cnt   <= CW'(T_RC - 2);
          nxt   <= (state == S_REF1) ? S_REF2 : S_MRS;
          state <= S_WAIT;
        end
        S_MRS: begin
          cmd      <= CMD_LMR;
          sdram_a  <= {3'b000, 1'b0, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b001};
          sdram_ba <= '0;
          cnt      <= '0;
          nxt      <= S_IDLE;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= nxt;
            if (nxt == S_IDLE) begin
              bus.ready <= 1'b1;
              sdram_dqm <= '0;
            end
          end
        end
        S_IDLE: begin
          if (ref_pend) begin
            cmd      <= CMD_REF;
            ref_pend <= 1'b0;
            cnt      <= CW'(T_RC - 2);
            nxt      <= S_IDLE;
            state    <= S_WAIT;
          end else if (bus.req) begin
            cmd      <= CMD_ACT;
            bus.ack  <= 1'b1;
            sdram_a  <= bus.addr[22:10];
            sdram_ba <= bus.addr[9:8];
            lat_col  <= bus.addr[7:0];
            lat_ba   <= bus.addr[9:8];
            lat_we   <= bus.we;
            lat_data <= bus.data;
            cnt      <= CW'(T_RCD - 1);
            state    <= S_ACT;
          end
        end
        S_ACT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            sdram_a  <= {2'b00, 1'b1, 1'b0, lat_col, 1'b0};
            sdram_ba <= lat_ba;
            if (lat_we) begin
              cmd    <= CMD_WR;
              dq_out <= lat_data[31:16];
              dq_oe  <= 1'b1;
              state  <= S_WR;
            end else begin
              cmd      <= CMD_RD;
              rd_sr[0] <= 1'b1;
              cnt      <= CW'(CAS_LATENCY);
              nxt      <= S_IDLE;
              state    <= S_WAIT;
            end
          end
        end
        S_WR: begin
          dq_out <= lat_data[15:0];
          dq_oe  <= 1'b1;
          cnt    <= CW'(2);
          nxt    <= S_IDLE;
          state  <= S_WAIT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_controller.sv
// Directed bench for sdram_controller with a behavioural burst-of-2 SDRAM
// model on the pins; every check is an immediate assertion.
module tb_sdram_controller;

  localparam int unsigned INIT = 30;
  localparam int unsigned REFR = 200;
  localparam int unsigned TRCD = 2;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRC  = 7;
  localparam int unsigned CL   = 2;
  localparam int unsigned LM   = INIT + TRP + 2 * TRC;

  localparam logic [3:0] C_LMR = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010,
                         C_ACT = 4'b0011, C_WR  = 4'b0100, C_RD  = 4'b0101,
                         C_NOP = 4'b0111, C_INH = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [1:0]  sdram_dqm;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  wire  [15:0] sdram_dq;
  logic [3:0]  cmd;

  logic [15:0] m_dq = '0;
  logic        m_oe = 1'b0;
  logic [15:0] mem [int];
  logic [12:0] m_row [4];
  int          m_rt = -1;
  int          m_rkey, m_wkey;
  logic        m_wpend = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          cyc = 0;
  int          er = 0;

  sdram_controller_if bus ();

  sdram_controller #(
    .INIT_CYCLES(INIT), .REFRESH_CYCLES(REFR), .T_RCD(TRCD),
    .T_RP(TRP), .T_RC(TRC), .CAS_LATENCY(CL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dq(sdram_dq),
    .sdram_dqm(sdram_dqm), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_cke(sdram_cke)
  );

  assign cmd      = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign sdram_dq = m_oe ? m_dq : 16'hzzzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: commands are taken mid-cycle; read beats are presented so
  // they are stable at the CL-th and (CL+1)-th rising edges after READ.
  always @(negedge clk) begin
    if (reset) begin
      m_oe = 1'b0; m_rt = -1; m_wpend = 1'b0;
    end else begin
      if (m_rt >= 0) begin
        m_rt = m_rt + 1;
        if (m_rt == CL) begin
          m_dq = mem.exists(m_rkey) ? mem[m_rkey] : 16'h0000; m_oe = 1'b1;
        end else if (m_rt == CL + 1) begin
          m_dq = mem.exists(m_rkey + 1) ? mem[m_rkey + 1] : 16'h0000;
        end else if (m_rt == CL + 2) begin
          m_oe = 1'b0; m_rt = -1;
        end
      end
      if (m_wpend) begin mem[m_wkey + 1] = sdram_dq; m_wpend = 1'b0; end
      case (cmd)
        C_ACT: m_row[sdram_ba] = sdram_a;
        C_RD: begin
          m_rkey = int'({sdram_ba, m_row[sdram_ba], sdram_a[8:0]}); m_rt = 0;
        end
        C_WR: begin
          m_wkey = int'({sdram_ba, m_row[sdram_ba], sdram_a[8:0]});
          mem[m_wkey] = sdram_dq; m_wpend = 1'b1;
        end
        default: ;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (bus.ack !== 1'b1 && n < 40);
    chk(tag, bus.ack, 1);
  endtask

  task automatic check_init();
    int unsigned bad = 0, acks = 0, early = 0;
    for (int k = 1; k <= int'(LM) + 1; k++) begin
      @(negedge clk);
      if (k == 1) chk("init_cke", sdram_cke, 1);
      if (k == int'(INIT)) begin
        chk("init_pre", cmd, C_PRE);
        chk("init_pre_a10", sdram_a[10], 1);
      end else if (k == int'(INIT + TRP)) begin
        chk("init_ref1", cmd, C_REF);
      end else if (k == int'(INIT + TRP + TRC)) begin
        chk("init_ref2", cmd, C_REF);
      end else if (k == int'(LM)) begin
        chk("init_lmr", cmd, C_LMR);
        chk("init_mode", sdram_a, 13'h021);
        chk("init_mode_ba", sdram_ba, 0);
      end else if (cmd !== C_NOP) begin
        bad++;
      end
      if (k <= int'(LM) && bus.ready) early++;
      if (bus.ack) acks++;
    end
    chk("init_nops", bad, 0);
    chk("init_no_ack", acks, 0);
    chk("init_ready_early", early, 0);
    chk("init_ready", bus.ready, 1);
    chk("init_dqm", sdram_dqm, 0);
    er = cyc;
  endtask

  // Entered at the cycle whose ACTIVE carries the ack.
  task automatic follow_read(input string t, input logic [22:0] a, input logic [31:0] exp);
    int unsigned bad = 0;
    chk({t, "_act"}, cmd, C_ACT);
    chk({t, "_row"}, sdram_a, a[22:10]);
    chk({t, "_ba"}, sdram_ba, a[9:8]);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.addr = ~a;
      if (c == 2) begin
        chk({t, "_rd"}, cmd, C_RD);
        chk({t, "_rd_a"}, sdram_a, {2'b00, 1'b1, 1'b0, a[7:0], 1'b0});
      end else if (c == 6) begin
        chk({t, "_valid"}, bus.valid, 1);
        chk({t, "_q"}, bus.q, exp);
      end else if (c == 7) begin
        chk({t, "_valid_end"}, bus.valid, 0);
      end else begin
        if (cmd !== C_NOP) bad++;
        if (bus.valid) bad++;
        if (bus.ack) bad++;
      end
    end
    chk({t, "_quiet"}, bad, 0);
  endtask

  task automatic follow_write(input string t, input logic [22:0] a, input logic [31:0] d);
    int unsigned bad = 0;
    chk({t, "_act"}, cmd, C_ACT);
    chk({t, "_row"}, sdram_a, a[22:10]);
    chk({t, "_ba"}, sdram_ba, a[9:8]);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.addr = ~a; bus.data = ~d; end
      if (c == 2) begin
        chk({t, "_wr"}, cmd, C_WR);
        chk({t, "_wr_a"}, sdram_a, {2'b00, 1'b1, 1'b0, a[7:0], 1'b0});
        chk({t, "_dq_hi"}, sdram_dq, d[31:16]);
      end else begin
        if (cmd !== C_NOP) bad++;
      end
      if (c == 3) chk({t, "_dq_lo"}, sdram_dq, d[15:0]);
      if (c == 4) chk({t, "_dq_rel"}, dut.dq_oe, 0);
      if (bus.valid) bad++;
      if (bus.ack) bad++;
    end
    chk({t, "_quiet"}, bad, 0);
  endtask

  initial begin
    int unsigned bad;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cke", sdram_cke, 0);
    chk("rst_cmd", cmd, C_INH);
    chk("rst_dqm", sdram_dqm, 2'b11);
    chk("rst_ready", bus.ready, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_ack_valid", {bus.ack, bus.valid}, 0);
    reset = 1'b0;
    check_init();

    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 23'h000405; bus.data = 32'hDEADBEEF;
    wait_ack("w0_ack");
    bus.req = 1'b0;
    follow_write("w0", 23'h000405, 32'hDEADBEEF);

    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 23'h7FFFFF; bus.data = 32'h12345678;
    wait_ack("w1_ack");
    bus.req = 1'b0;
    follow_write("w1", 23'h7FFFFF, 32'h12345678);

    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h000405;
    wait_ack("r0_ack");
    bus.req = 1'b0;
    follow_read("r0", 23'h000405, 32'hDEADBEEF);

    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h000405;
    wait_ack("b2b_ack0");
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.addr = 23'h7FFFFF;
      if (c == 2) chk("b2b_rd0", cmd, C_RD);
      else if (cmd !== C_NOP) bad++;
      if (bus.ack) bad++;
      if (bus.valid) bad++;
    end
    chk("b2b_quiet", bad, 0);
    @(negedge clk);
    chk("b2b_ack6", bus.ack, 1);
    chk("b2b_valid6", bus.valid, 1);
    chk("b2b_q0", bus.q, 32'hDEADBEEF);
    bus.req = 1'b0;
    follow_read("b2b1", 23'h7FFFFF, 32'h12345678);

    // Refresh becomes pending in cycle er+REFR; req rises in that same cycle.
    chk("rf_setup", cyc < er + int'(REFR), 1);
    while (cyc < er + int'(REFR)) @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h7FFFFF;
    @(negedge clk);
    chk("rf_cmd", cmd, C_REF);
    chk("rf_no_ack", bus.ack, 0);
    bad = 0;
    for (int i = 1; i < int'(TRC); i++) begin
      @(negedge clk);
      if (bus.ack) bad++;
      if (cmd !== C_NOP) bad++;
    end
    chk("rf_wait", bad, 0);
    @(negedge clk);
    chk("rf_ack", bus.ack, 1);
    bus.req = 1'b0;
    follow_read("rf", 23'h7FFFFF, 32'h12345678);

    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h000405;
    wait_ack("mr_ack");
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_cke", sdram_cke, 0);
    chk("mr_cmd", cmd, C_INH);
    chk("mr_q", bus.q, 0);
    chk("mr_ready", bus.ready, 0);
    chk("mr_dqm", sdram_dqm, 2'b11);
    chk("mr_dq_rel", dut.dq_oe, 0);
    bus.req = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.valid) bad++;
      if (bus.ack) bad++;
    end
    chk("mr_no_valid", bad, 0);
    reset = 1'b0;
    check_init();
    @(negedge clk);
    chk("mr_ack_after_ready", bus.ack, 1);
    bus.req = 1'b0;
    follow_read("mr", 23'h000405, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
